// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file for the pipelined CPU.
//   - NRD combinational core read ports (write-first forwarding) with busy flags
//   - two write ports (wr1 wins on an address collision)
//   - per-register busy scoreboard (set by busy_set_en, cleared by writes)
//   - combinational debug read port (dbg_addr/dbg_data)
//   - scan engine dumping one entry per cycle to the SDU
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   rd_addr/rd_data/rd_busy           packed core read ports, port i at [i*W +: W]
//   wr0_*/wr1_*                       write ports
//   busy_set_en/busy_set_addr         scoreboard set request
//   dbg_addr/dbg_data                 SDU read port
//   scan_start/busy/valid/idx/data/done  scan engine control and output stream
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  wr0_en,
  input  logic [ADDR_W-1:0]     wr0_addr,
  input  logic [DATA_W-1:0]     wr0_data,
  input  logic                  wr1_en,
  input  logic [ADDR_W-1:0]     wr1_addr,
  input  logic [DATA_W-1:0]     wr1_data,
  input  logic                  busy_set_en,
  input  logic [ADDR_W-1:0]     busy_set_addr,
  input  logic [ADDR_W-1:0]     dbg_addr,
  output logic [DATA_W-1:0]     dbg_data,
  input  logic                  scan_start,
  output logic                  scan_busy,
  output logic                  scan_valid,
  output logic [ADDR_W-1:0]     scan_idx,
  output logic [DATA_W-1:0]     scan_data,
  output logic                  scan_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } scan_state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] rf [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              w0_ok;
  logic              w1_ok;

  scan_state_t       state;
  scan_state_t       state_next;
  logic [ADDR_W-1:0] k;
  logic [DATA_W-1:0] scan_v;

  // Writes to entry 0 are dropped entirely when it is hardwired to zero.
  assign w0_ok = wr0_en && !(ZERO_REG && (wr0_addr == '0));
  assign w1_ok = wr1_en && !(ZERO_REG && (wr1_addr == '0));

  function automatic logic hit(input logic ok, input logic [ADDR_W-1:0] wa,
                               input logic [ADDR_W-1:0] a);
    return ok && (wa == a);
  endfunction

  // Write-first effective value of entry a.
  function automatic logic [DATA_W-1:0] eff(
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] stored,
    input logic              h0,
    input logic              h1,
    input logic [DATA_W-1:0] d0,
    input logic [DATA_W-1:0] d1
  );
    if (ZERO_REG && (a == '0)) return '0;
    if (h1) return d1;
    if (h0) return d0;
    return stored;
  endfunction

  // Storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned j = 0; j < DEPTH; j++) rf[j] <= '0;
    end else begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (hit(w1_ok, wr1_addr, ADDR_W'(j)))      rf[j] <= wr1_data;
        else if (hit(w0_ok, wr0_addr, ADDR_W'(j))) rf[j] <= wr0_data;
      end
    end
  end

  // Scoreboard: a set in the same cycle as a completing write wins, since it
  // marks a newly issued producer for that register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (busy_set_en && (busy_set_addr == ADDR_W'(j)) && !(ZERO_REG && (j == 0)))
          busy[j] <= 1'b1;
        else if (hit(w0_ok, wr0_addr, ADDR_W'(j)) || hit(w1_ok, wr1_addr, ADDR_W'(j)))
          busy[j] <= 1'b0;
      end
    end
  end

  // Core read ports: forwarded data is never reported busy.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      logic [ADDR_W-1:0] a;
      logic              h0;
      logic              h1;
      a  = rd_addr[i*ADDR_W +: ADDR_W];
      h0 = hit(w0_ok, wr0_addr, a);
      h1 = hit(w1_ok, wr1_addr, a);
      rd_data[i*DATA_W +: DATA_W] = eff(a, rf[a], h0, h1, wr0_data, wr1_data);
      rd_busy[i] = busy[a] && !h0 && !h1;
    end
  end

  assign dbg_data = eff(dbg_addr, rf[dbg_addr],
                        hit(w0_ok, wr0_addr, dbg_addr), hit(w1_ok, wr1_addr, dbg_addr),
                        wr0_data, wr1_data);

  assign scan_v = eff(k, rf[k], hit(w0_ok, wr0_addr, k), hit(w1_ok, wr1_addr, k),
                      wr0_data, wr1_data);

  // Scan FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (scan_start) state_next = S_SCAN;
      S_SCAN:  if (k == LAST) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign scan_busy = (state != S_IDLE);

  // Scan outputs are registered; idx/data hold their last value outside SCAN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k          <= '0;
      scan_idx   <= '0;
      scan_data  <= '0;
      scan_valid <= 1'b0;
      scan_done  <= 1'b0;
    end else begin
      case (state)
        S_SCAN: begin
          scan_idx   <= k;
          scan_data  <= scan_v;
          scan_valid <= 1'b1;
          scan_done  <= 1'b0;
          k          <= (k == LAST) ? '0 : k + 1'b1;
        end
        S_DONE: begin
          scan_valid <= 1'b0;
          scan_done  <= 1'b1;
        end
        default: begin
          scan_valid <= 1'b0;
          scan_done  <= 1'b0;
          k          <= '0;
        end
      endcase
    end
  end

endmodule
